// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main control FSM with retire counter and memory-timeout watchdog.
module mc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             pcsrc,
    output logic             alusrc,
    output logic [1:0]       aluop,
    output logic             regwrite,
    output logic             memtoreg,
    output logic             trap,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, MEMADR = 4'd4, MEMRD = 4'd5,
        MEMWR = 4'd6, WB_ALU = 4'd7, WB_MEM = 4'd8, BRANCH = 4'd9, TRAP = 4'd10
    } state_t;
    state_t st, nxt;
    logic [WW-1:0] wcnt;
    logic expired, waiting, taken, retire, is_i;
    assign expired = wcnt == WW'(TIMEOUT);
    assign waiting = (st == FETCH || st == MEMRD || st == MEMWR) && !mem_ready;
    assign taken   = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
    assign is_i    = opcode == 7'b0010011;
    assign retire  = st != FETCH && nxt == FETCH;
    assign state   = st;
    always_comb begin
        nxt = st;
        case (st)
            FETCH:  nxt = mem_ready ? DECODE : expired ? TRAP : FETCH;
            DECODE: nxt = opcode == 7'b0110011 ? EXEC_R :
                          is_i ? EXEC_I :
                          (opcode == 7'b0000011 || opcode == 7'b0100011) ? MEMADR :
                          (opcode == 7'b1100011 && funct3[2:1] == 2'b00) ? BRANCH : TRAP;
            EXEC_R, EXEC_I: nxt = WB_ALU;
            MEMADR: nxt = opcode == 7'b0000011 ? MEMRD : MEMWR;
            MEMRD:  nxt = mem_ready ? WB_MEM : expired ? TRAP : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : expired ? TRAP : MEMWR;
            WB_ALU, WB_MEM, BRANCH: nxt = FETCH;
            default: nxt = TRAP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= FETCH;
            instret <= '0;
            wcnt    <= '0;
        end else begin
            st      <= nxt;
            instret <= instret + CNT_W'(retire);
            wcnt    <= (waiting && nxt == st) ? wcnt + WW'(1) : '0;
        end
    end
    // WB_ALU keeps the EXEC operand selection, recovered from the still-stable opcode
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsrc    = 1'b0;
        alusrc   = 1'b0;
        aluop    = 2'b00;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        trap     = 1'b0;
        if (!reset) begin
            case (st)
                FETCH: begin
                    memread = 1'b1;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                EXEC_R: aluop = 2'b10;
                EXEC_I: begin
                    alusrc = 1'b1;
                    aluop  = 2'b11;
                end
                MEMADR: alusrc = 1'b1;
                MEMRD: begin
                    memread = 1'b1;
                    alusrc  = 1'b1;
                end
                MEMWR: begin
                    memwrite = 1'b1;
                    alusrc   = 1'b1;
                end
                WB_ALU: begin
                    regwrite = 1'b1;
                    alusrc   = is_i;
                    aluop    = is_i ? 2'b11 : 2'b10;
                end
                WB_MEM: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                BRANCH: begin
                    aluop   = 2'b01;
                    pcwrite = taken;
                    pcsrc   = taken;
                end
                TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed vector table plus multi-cycle corner sequences for mc_ctrl.
module tb_mc_ctrl;
    localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011,
                           SW = 7'b0100011, BR = 7'b1100011, BAD = 7'b1111111;
    // control bits: memread memwrite irwrite pcwrite pcsrc alusrc aluop[1:0] regwrite memtoreg trap
    localparam logic [10:0] C_0 = 11'b00000000000, C_FR = 11'b10110000000, C_FW = 11'b10000000000,
                            C_XR = 11'b00000010000, C_XI = 11'b00000111000, C_WR = 11'b00000010100,
                            C_WI = 11'b00000111100, C_MA = 11'b00000100000, C_RD = 11'b10000100000,
                            C_WRM = 11'b01000100000, C_WM = 11'b00000000110, C_BT = 11'b00011001000,
                            C_BN = 11'b00000001000, C_TR = 11'b00000000001;
    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, regwrite, memtoreg, trap;
    logic [1:0] aluop;
    logic [3:0] state, instret;
    logic [10:0] ctl;
    int passed = 0, total = 0;
    typedef struct packed {
        logic rst; logic [6:0] op; logic [2:0] f3; logic z; logic rdy;
        logic [3:0] st; logic [10:0] ctl; logic [3:0] ir;
    } vec_t;
    vec_t v[$];
    always #5 clk = ~clk;
    mc_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop), .regwrite(regwrite),
        .memtoreg(memtoreg), .trap(trap), .state(state), .instret(instret)
    );
    assign ctl = {memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, aluop, regwrite, memtoreg, trap};
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    endtask
    task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic z, input logic rdy);
        @(negedge clk);
        reset = r; opcode = op; funct3 = f3; zero = z; mem_ready = rdy;
        #1;
    endtask
    task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [10:0] c, input logic [3:0] ir);
        v.push_back({r, op, f3, z, rdy, st, c, ir});
    endtask
    task automatic run_addi();
        repeat (4) step(1'b0, ADDI, 3'b000, 1'b0, 1'b1);
    endtask
    initial begin
        int n;
        logic [3:0] ir0;
        add(1, ADD, 0, 0, 1, 0, C_0, 0);
        add(0, ADD, 0, 0, 1, 0, C_FR, 0);
        add(0, ADD, 0, 0, 1, 1, C_0, 0);
        add(0, ADD, 0, 0, 1, 2, C_XR, 0);
        add(0, ADD, 0, 0, 1, 7, C_WR, 0);
        add(0, ADD, 0, 0, 0, 0, C_FW, 1);
        add(0, LW, 0, 0, 1, 0, C_FR, 1);
        add(0, LW, 0, 0, 1, 1, C_0, 1);
        add(0, LW, 0, 0, 1, 4, C_MA, 1);
        add(0, LW, 0, 0, 0, 5, C_RD, 1);
        add(0, LW, 0, 0, 0, 5, C_RD, 1);
        add(0, LW, 0, 0, 1, 5, C_RD, 1);
        add(0, LW, 0, 0, 1, 8, C_WM, 1);
        add(0, SW, 0, 0, 1, 0, C_FR, 2);
        add(0, SW, 0, 0, 1, 1, C_0, 2);
        add(0, SW, 0, 0, 1, 4, C_MA, 2);
        add(0, SW, 0, 0, 0, 6, C_WRM, 2);
        add(0, SW, 0, 0, 1, 6, C_WRM, 2);
        add(0, BR, 0, 1, 1, 0, C_FR, 3);
        add(0, BR, 0, 1, 1, 1, C_0, 3);
        add(0, BR, 0, 1, 1, 9, C_BT, 3);
        add(0, BR, 1, 1, 1, 0, C_FR, 4);
        add(0, BR, 1, 1, 1, 1, C_0, 4);
        add(0, BR, 1, 1, 1, 9, C_BN, 4);
        add(0, BR, 1, 0, 1, 0, C_FR, 5);
        add(0, BR, 1, 0, 1, 1, C_0, 5);
        add(0, BR, 1, 0, 1, 9, C_BT, 5);
        add(0, ADDI, 0, 0, 1, 0, C_FR, 6);
        add(0, ADDI, 0, 0, 1, 1, C_0, 6);
        add(0, ADDI, 0, 0, 1, 3, C_XI, 6);
        add(0, ADDI, 0, 0, 1, 7, C_WI, 6);
        add(0, ADDI, 0, 0, 0, 0, C_FW, 7);
        repeat (2) step(1'b1, ADD, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < v.size(); i++) begin
            step(v[i].rst, v[i].op, v[i].f3, v[i].z, v[i].rdy);
            chk("vec_state", i, 32'(state), 32'(v[i].st));
            chk("vec_ctl", i, 32'(ctl), 32'(v[i].ctl));
            chk("vec_instret", i, 32'(instret), 32'(v[i].ir));
        end
        // illegal opcode, then branch with an unsupported funct3
        for (int k = 0; k < 2; k++) begin
            step(1'b1, ADD, 3'b000, 1'b0, 1'b1);
            chk("trap_rst_ctl", k, 32'(ctl), 32'(C_0));
            repeat (4) step(1'b0, ADD, 3'b000, 1'b0, 1'b1);
            step(1'b0, k == 0 ? BAD : BR, k == 0 ? 3'b000 : 3'b010, 1'b0, 1'b1);
            chk("trap_fetch", k, 32'(state), 32'd0);
            step(1'b0, k == 0 ? BAD : BR, k == 0 ? 3'b000 : 3'b010, 1'b0, 1'b1);
            chk("trap_decode", k, 32'(state), 32'd1);
            n = 0;
            for (int c = 0; c < 21; c++) begin
                step(1'b0, k == 0 ? BAD : BR, k == 0 ? 3'b000 : 3'b010, 1'b0, c[0]);
                if (state == 4'd10 && ctl == C_TR && instret == 4'd1) n++;
            end
            chk("trap_hold_cycles", k, 32'(n), 32'd21);
            step(1'b1, ADD, 3'b000, 1'b0, 1'b1);
            chk("trap_reset_trap", k, 32'(trap), 32'd0);
            step(1'b0, ADD, 3'b000, 1'b0, 1'b0);
            chk("trap_exit_state", k, 32'(state), 32'd0);
            chk("trap_exit_instret", k, 32'(instret), 32'd0);
        end
        // watchdog: fetch stall until trap
        step(1'b1, ADD, 3'b000, 1'b0, 1'b0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, ADD, 3'b000, 1'b0, 1'b0);
            if (state != 4'd0) break;
            n++;
        end
        chk("wd_fetch_cycles", 0, 32'(n), 32'd5);
        chk("wd_trap_state", 0, 32'(state), 32'd10);
        // stall of four cycles recovering just in time
        step(1'b1, ADD, 3'b000, 1'b0, 1'b0);
        repeat (4) step(1'b0, ADD, 3'b000, 1'b0, 1'b0);
        chk("wd_edge_state", 0, 32'(state), 32'd0);
        step(1'b0, ADD, 3'b000, 1'b0, 1'b1);
        chk("wd_edge_ctl", 0, 32'(ctl), 32'(C_FR));
        step(1'b0, ADD, 3'b000, 1'b0, 1'b1);
        chk("wd_edge_decode", 0, 32'(state), 32'd1);
        // retire counter wrap with a 4-bit counter
        step(1'b1, ADDI, 3'b000, 1'b0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            run_addi();
            @(posedge clk);
            #1;
            chk("wrap_instret", k, 32'(instret), 32'(k % 16));
        end
        // reset during a store stall abandons the store
        step(1'b1, SW, 3'b000, 1'b0, 1'b1);
        run_addi();
        repeat (3) step(1'b0, SW, 3'b000, 1'b0, 1'b1);
        step(1'b0, SW, 3'b000, 1'b0, 1'b0);
        chk("rstwr_state", 0, 32'(state), 32'd6);
        chk("rstwr_memwrite", 0, 32'(memwrite), 32'd1);
        ir0 = instret;
        chk("rstwr_instret_pre", 0, 32'(ir0), 32'd1);
        step(1'b1, SW, 3'b000, 1'b0, 1'b0);
        chk("rstwr_memwrite_drop", 0, 32'(memwrite), 32'd0);
        step(1'b0, SW, 3'b000, 1'b0, 1'b0);
        chk("rstwr_state_post", 0, 32'(state), 32'd0);
        chk("rstwr_instret_post", 0, 32'(instret), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main control FSM for the RV32-subset core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback over a shared ALU and a single unified memory port. It drives the 2-bit `aluop` consumed by the ALU control decoder, along with all register-file, memory, IR and PC enables. It also keeps a retired-instruction counter and a memory-timeout watchdog that traps the core.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.
- `TIMEOUT`, 255: maximum wait cycles on `mem_ready` before trapping; must be ≥1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 7: `instr[6:0]` from the IR; stable from DECODE onward.
- `funct3` in 3: `instr[14:12]` from the IR.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `memread` out 1: memory read request.
- `memwrite` out 1: memory write request.
- `irwrite` out 1: load the IR from memory read data.
- `pcwrite` out 1: update the PC.
- `pcsrc` out 1: PC source; 0 selects PC+4, 1 selects the branch target.
- `alusrc` out 1: ALU operand B; 0 selects rs2, 1 selects the immediate.
- `aluop` out 2: 00 add (ld/sd), 01 branch, 10 R-type, 11 I-type.
- `regwrite` out 1: register-file write enable.
- `memtoreg` out 1: writeback source; 0 selects the ALU, 1 selects memory.
- `trap` out 1: sticky trap flag.
- `state` out 4: current state encoding, for debug.
- `instret` out CNT_W: count of retired instructions.

## Operation
State encodings:
- 0 FETCH, 1 DECODE, 2 EXEC_R, 3 EXEC_I, 4 MEMADR, 5 MEMRD, 6 MEMWR, 7 WB_ALU, 8 WB_MEM, 9 BRANCH, 10 TRAP.
- Outputs are a Moore decode of the state, except that `irwrite`, `pcwrite` and `pcsrc` are also gated by `mem_ready` or `zero` as stated below.
- Any output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH: `memread`=1. If `mem_ready`=1, also `irwrite`=1 and `pcwrite`=1 (`pcsrc`=0), then go to DECODE. Otherwise stay in FETCH.
- DECODE: no outputs. Next state by opcode:
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → MEMADR.
  - 1100011 with `funct3` ∈ {000, 001} → BRANCH.
  - Anything else → TRAP.
- EXEC_R: `alusrc`=0, `aluop`=10 → WB_ALU.
- EXEC_I: `alusrc`=1, `aluop`=11 → WB_ALU.
- MEMADR: `alusrc`=1, `aluop`=00. Go to MEMRD if opcode is 0000011, else MEMWR.
- MEMRD: `memread`=1, `alusrc`=1, `aluop`=00. Go to WB_MEM when `mem_ready`=1, otherwise hold.
- MEMWR: `memwrite`=1, `alusrc`=1, `aluop`=00. Go to FETCH when `mem_ready`=1, otherwise hold. This transition retires the instruction.
- WB_ALU: `regwrite`=1, `memtoreg`=0, and `alusrc`/`aluop` held at their EXEC values → FETCH (retires).
- WB_MEM: `regwrite`=1, `memtoreg`=1 → FETCH (retires).
- BRANCH: `alusrc`=0, `aluop`=01. Define taken = (`funct3`=000 & `zero`) | (`funct3`=001 & !`zero`). If taken, `pcwrite`=1 and `pcsrc`=1. Always go to FETCH (retires).
- TRAP: `trap`=1. All other control outputs are 0. TRAP is absorbing; only `reset` exits it.

Retire counter:
- `instret` increments by 1 on every retiring transition into FETCH.
- It wraps modulo 2^CNT_W.
- Trapped instructions do not retire.

Watchdog:
- A wait counter of width clog2(TIMEOUT+1) counts the consecutive cycles spent in FETCH, MEMRD or MEMWR with `mem_ready`=0.
- It clears on any state change and whenever `mem_ready`=1.
- When the counter reaches TIMEOUT while `mem_ready` is still 0, the next state is TRAP.

## Timing
Reset:
- While `reset`=1, every control output and `trap` are forced to 0.
- On the first edge with `reset`=1: `state`=FETCH, `instret`=0, wait counter cleared.
- A reset asserted mid-instruction abandons that instruction; it does not retire.

Latency with zero-wait memory (`mem_ready` tied to 1):
- Branch: 3 cycles.
- R-type, I-type, store: 4 cycles.
- Load: 5 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.

Handshake:
- `memread`/`memwrite` stay asserted, with the address held, until the cycle in which `mem_ready`=1.
- `mem_ready` is ignored in every other state.

Other cycle-level rules:
- `instret` is visible incremented in the cycle after the retiring cycle.
- Watchdog: if the first FETCH cycle after reset is wait count 0, then with `mem_ready` held at 0 the state enters TRAP after exactly TIMEOUT+1 FETCH cycles.

## Test plan
- Reset, then issue `add` (opcode 0110011) with `mem_ready`=1 → states 0, 1, 2, 7, 0; `regwrite`=1 only in state 7; `aluop`=10; `instret` goes 0→1.
- `lw`, with `mem_ready`=0 for the first 2 MEMRD cycles → states 0, 1, 4, 5, 5, 5, 8, 0; `memtoreg`=1 in state 8; 7 cycles total.
- `beq` with `zero`=1 → `pcwrite`=1, `pcsrc`=1 in BRANCH. `bne` with `zero`=1 → `pcwrite`=0. Both retire.
- Opcode 1111111, and separately branch opcode with `funct3`=010 → TRAP after DECODE; `trap` stays 1 for 20 more cycles; `instret` unchanged; `reset` returns to FETCH with `trap`=0.
- TIMEOUT=4, `mem_ready` held at 0 in FETCH → TRAP after exactly 5 FETCH cycles. Same stall ending with `mem_ready`=1 after 4 FETCH cycles → no trap.
- CNT_W=4, run 17 `addi` instructions → `instret` wraps 15→0 and ends at 1. `reset` asserted during a MEMWR stall → `memwrite` drops immediately and `instret`=0.
